// File: rtl/srec_loader_if.sv
// Byte-stream input and instruction-memory write port of the S-record loader.
// Latency: none (wires only).
// Backpressure: rx_ready from the loader gates rx_valid from the host.
interface srec_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        srec_parse;
  logic [31:0] srec_address;
  logic [31:0] srec_data_in;
  logic        srec_rw;
  logic [1:0]  srec_access_size;
  logic [31:0] entry_point;
  logic        done;
  logic        error;
  logic [2:0]  error_code;

  // Host / bench side: drives the ASCII stream, observes the memory port
  modport master (
    output rx_data, rx_valid,
    input  rx_ready, srec_parse, srec_address, srec_data_in, srec_rw,
    input  srec_access_size, entry_point, done, error, error_code
  );

  // Loader side
  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, srec_parse, srec_address, srec_data_in, srec_rw,
    output srec_access_size, entry_point, done, error, error_code
  );
endinterface

// File: rtl/srec_loader.sv
// Motorola S-record parser writing whole 32-bit words into instruction memory.
// Latency: a word write strobes one cycle after its last data nibble is taken.
// Backpressure: rx_ready drops for the single write cycle and forever in DONE/ERROR.
module srec_loader #(
  parameter logic [31:0] ADDR_OFFSET      = 32'h0000_0000,
  parameter logic [1:0]  WORD_ACCESS_SIZE = 2'b00
) (
  input  logic          clk,
  input  logic          rst_n,
  srec_loader_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE, TYPE, COUNT, ADDR, DATA, CKSUM, WRITE, DONE, ERROR
  } state_t;

  state_t      state;
  logic [2:0]  addr_len;
  logic        is_wr;
  logic        is_term;
  logic [7:0]  bytes_left;
  logic [7:0]  data_len;
  logic        have_hi;
  logic [3:0]  hi_nib;
  logic [7:0]  sum;
  logic [31:0] addr;
  logic [31:0] word_buf;
  logic [1:0]  lane;

  logic        take;
  logic        hex_ok;
  logic [3:0]  hex_val;
  logic [7:0]  rx_byte;
  logic [7:0]  sum_next;
  logic [31:0] buf_next;
  logic        type_ok;
  logic [2:0]  type_alen;
  logic        type_wr;
  logic        type_term;
  logic        fail;
  logic [2:0]  fail_code;

  assign take     = bus.rx_valid & bus.rx_ready;
  assign rx_byte  = {hi_nib, hex_val};
  assign sum_next = sum + rx_byte;

  // ASCII hex digit decode (either letter case)
  always_comb begin
    hex_ok  = 1'b1;
    hex_val = 4'h0;
    if (bus.rx_data >= 8'h30 && bus.rx_data <= 8'h39)
      hex_val = bus.rx_data[3:0];
    else if ((bus.rx_data >= 8'h41 && bus.rx_data <= 8'h46) ||
             (bus.rx_data >= 8'h61 && bus.rx_data <= 8'h66))
      hex_val = bus.rx_data[3:0] + 4'd9;
    else
      hex_ok = 1'b0;
  end

  // Record type digit -> address width and record class
  always_comb begin
    type_ok   = 1'b1;
    type_alen = 3'd2;
    type_wr   = 1'b0;
    type_term = 1'b0;
    case (bus.rx_data)
      8'h30, 8'h35: type_alen = 3'd2;
      8'h31: begin type_alen = 3'd2; type_wr = 1'b1; end
      8'h32: begin type_alen = 3'd3; type_wr = 1'b1; end
      8'h33: begin type_alen = 3'd4; type_wr = 1'b1; end
      8'h37: begin type_alen = 3'd4; type_term = 1'b1; end
      8'h38: begin type_alen = 3'd3; type_term = 1'b1; end
      8'h39: begin type_alen = 3'd2; type_term = 1'b1; end
      default: type_ok = 1'b0;
    endcase
  end

  // Drop the completed data byte into the next free big-endian lane
  always_comb begin
    buf_next = word_buf;
    case (lane)
      2'd0: buf_next[31:24] = rx_byte;
      2'd1: buf_next[23:16] = rx_byte;
      2'd2: buf_next[15:8]  = rx_byte;
      default: buf_next[7:0] = rx_byte;
    endcase
  end

  // Detect the parse failure (if any) caused by the byte taken this cycle
  always_comb begin
    fail      = 1'b0;
    fail_code = 3'd0;
    if (take) begin
      case (state)
        IDLE: if (bus.rx_data != 8'h53 && bus.rx_data != 8'h0D &&
                  bus.rx_data != 8'h0A && bus.rx_data != 8'h20) begin
          fail = 1'b1; fail_code = 3'd6;
        end
        TYPE: if (!type_ok) begin
          fail = 1'b1; fail_code = 3'd3;
        end
        COUNT, ADDR, DATA, CKSUM: begin
          if (!hex_ok) begin
            fail = 1'b1; fail_code = 3'd1;
          end else if (have_hi) begin
            if (state == COUNT && rx_byte < ({5'd0, addr_len} + 8'd1)) begin
              fail = 1'b1; fail_code = 3'd5;
            end else if (state == ADDR && bytes_left == 8'd1 && is_wr &&
                         rx_byte[1:0] != 2'b00) begin
              fail = 1'b1; fail_code = 3'd4;
            end else if (state == CKSUM && sum_next != 8'hFF) begin
              fail = 1'b1; fail_code = 3'd2;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Record parser FSM with registered memory-port and status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= IDLE;
      addr_len             <= 3'd2;
      is_wr                <= 1'b0;
      is_term              <= 1'b0;
      bytes_left           <= 8'd0;
      data_len             <= 8'd0;
      have_hi              <= 1'b0;
      hi_nib               <= 4'h0;
      sum                  <= 8'd0;
      addr                 <= 32'd0;
      word_buf             <= 32'd0;
      lane                 <= 2'd0;
      bus.rx_ready         <= 1'b1;
      bus.srec_parse       <= 1'b1;
      bus.srec_address     <= 32'd0;
      bus.srec_data_in     <= 32'd0;
      bus.srec_rw          <= 1'b0;
      bus.srec_access_size <= WORD_ACCESS_SIZE;
      bus.entry_point      <= 32'd0;
      bus.done             <= 1'b0;
      bus.error            <= 1'b0;
      bus.error_code       <= 3'd0;
    end else if (fail) begin
      state          <= ERROR;
      bus.error      <= 1'b1;
      bus.error_code <= fail_code;
      bus.rx_ready   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take && bus.rx_data == 8'h53) begin
          state    <= TYPE;
          sum      <= 8'd0;
          addr     <= 32'd0;
          word_buf <= 32'd0;
          lane     <= 2'd0;
          have_hi  <= 1'b0;
        end
        TYPE: if (take) begin
          addr_len <= type_alen;
          is_wr    <= type_wr;
          is_term  <= type_term;
          state    <= COUNT;
        end
        COUNT, ADDR, DATA, CKSUM: if (take) begin
          if (!have_hi) begin
            hi_nib  <= hex_val;
            have_hi <= 1'b1;
          end else begin
            have_hi <= 1'b0;
            sum     <= sum_next;
            case (state)
              COUNT: begin
                data_len   <= rx_byte - {5'd0, addr_len} - 8'd1;
                bytes_left <= {5'd0, addr_len};
                state      <= ADDR;
              end
              ADDR: begin
                addr       <= {addr[23:0], rx_byte};
                bytes_left <= bytes_left - 8'd1;
                if (bytes_left == 8'd1) begin
                  if (data_len == 8'd0) begin
                    state <= CKSUM;
                  end else begin
                    state      <= DATA;
                    bytes_left <= data_len;
                  end
                end
              end
              DATA: begin
                bytes_left <= bytes_left - 8'd1;
                if (is_wr) begin
                  // Full word, or a short tail at the end of the record
                  if (lane == 2'd3 || bytes_left == 8'd1) begin
                    state            <= WRITE;
                    bus.srec_rw      <= 1'b1;
                    bus.srec_address <= addr + ADDR_OFFSET;
                    bus.srec_data_in <= buf_next;
                    bus.rx_ready     <= 1'b0;
                    addr             <= addr + 32'd4;
                    word_buf         <= 32'd0;
                    lane             <= 2'd0;
                  end else begin
                    word_buf <= buf_next;
                    lane     <= lane + 2'd1;
                  end
                end else if (bytes_left == 8'd1) begin
                  state <= CKSUM;
                end
              end
              default: begin
                // CKSUM already verified good here
                if (is_term) begin
                  bus.entry_point <= addr;
                  bus.done        <= 1'b1;
                  bus.srec_parse  <= 1'b0;
                  bus.rx_ready    <= 1'b0;
                  state           <= DONE;
                end else begin
                  state <= IDLE;
                end
              end
            endcase
          end
        end
        WRITE: begin
          bus.srec_rw  <= 1'b0;
          bus.rx_ready <= 1'b1;
          state        <= (bytes_left == 8'd0) ? CKSUM : DATA;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_srec_loader.sv
// Self-checking bench for srec_loader: directed records plus a random record stream.
// Latency: expectations compared a few cycles after each stream completes.
// Backpressure: the byte driver waits (bounded) on rx_ready before each byte.
`timescale 1ns/1ps
module tb_srec_loader;
  localparam logic [31:0] OFFS = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  sz;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  srec_loader_if bus();

  srec_loader #(.ADDR_OFFSET(OFFS), .WORD_ACCESS_SIZE(2'b00)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Observed side: every write strobe, strobe width, and rx_ready stalls
  wr_t got_q[$];
  int  rw_run = 0;
  int  rw_max = 0;
  int  rdy_low = 0;

  always @(negedge clk) begin
    if (bus.srec_rw === 1'b1) begin
      got_q.push_back(wr_t'{bus.srec_address, bus.srec_data_in, bus.srec_access_size});
      rw_run++;
      if (rw_run > rw_max) rw_max = rw_run;
    end else begin
      rw_run = 0;
    end
    if (rst_n && !bus.rx_ready && !bus.done && !bus.error) rdy_low++;
  end

  // Reference model: expected writes and final status derived from the text
  wr_t         exp_q[$];
  int          exp_code;
  bit          exp_done;
  logic [31:0] exp_entry;
  int          n_acc;

  function automatic int hexv(input logic [7:0] c);
    if (c >= "0" && c <= "9") return int'(c) - 48;
    if (c >= "A" && c <= "F") return int'(c) - 55;
    if (c >= "a" && c <= "f") return int'(c) - 87;
    return -1;
  endfunction

  // r: 0 = byte read, 1 = non-hex char consumed, 2 = stream ended
  task automatic rd(input string s, inout int i, output int v, output int r);
    int h, l;
    v = 0;
    r = 2;
    if (i >= s.len()) return;
    h = hexv(s[i]); i++;
    if (h < 0) begin r = 1; return; end
    if (i >= s.len()) return;
    l = hexv(s[i]); i++;
    if (l < 0) begin r = 1; return; end
    v = h * 16 + l;
    r = 0;
  endtask

  task automatic model_stream(input string s);
    int          i, alen, cnt, v, r, sum, dl, nb;
    logic [31:0] a, w;
    logic [7:0]  c;
    bit          wr, term, stop;
    i = 0; stop = 0;
    exp_q.delete();
    exp_code = 0;
    exp_done = 0;
    while (i < s.len() && !stop) begin
      c = s[i]; i++;
      if (c == " " || c == 8'h0D || c == 8'h0A) continue;
      if (c != "S") begin exp_code = 6; break; end
      if (i >= s.len()) break;
      c = s[i]; i++;
      case (c)
        "0", "1", "5", "9": alen = 2;
        "2", "8":           alen = 3;
        "3", "7":           alen = 4;
        default:            alen = 0;
      endcase
      if (alen == 0) begin exp_code = 3; break; end
      wr   = (c == "1" || c == "2" || c == "3");
      term = (c == "7" || c == "8" || c == "9");
      rd(s, i, cnt, r);
      if (r == 1) exp_code = 1;
      if (r != 0) break;
      if (cnt < alen + 1) begin exp_code = 5; break; end
      sum = cnt;
      a = 0;
      for (int k = 0; k < alen && !stop; k++) begin
        rd(s, i, v, r);
        if (r == 1) exp_code = 1;
        if (r != 0) stop = 1;
        else begin a = (a << 8) | 32'(v); sum += v; end
      end
      if (stop) break;
      if (wr && a[1:0] != 2'b00) begin exp_code = 4; break; end
      dl = cnt - alen - 1;
      w = 0; nb = 0;
      for (int k = 0; k < dl && !stop; k++) begin
        rd(s, i, v, r);
        if (r == 1) exp_code = 1;
        if (r != 0) stop = 1;
        else begin
          sum += v;
          if (wr) begin
            w[31 - 8*nb -: 8] = v[7:0];
            nb++;
            if (nb == 4 || k == dl - 1) begin
              exp_q.push_back(wr_t'{a + OFFS, w, 2'b00});
              a = a + 32'd4;
              w = 0; nb = 0;
            end
          end
        end
      end
      if (stop) break;
      rd(s, i, v, r);
      if (r == 1) exp_code = 1;
      if (r != 0) break;
      sum += v;
      if (sum % 256 != 255) begin exp_code = 2; break; end
      if (term) begin exp_done = 1; exp_entry = a; break; end
    end
    n_acc = (exp_code != 0 || exp_done) ? i : s.len();
  endtask

  // Stimulus
  task automatic apply_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    got_q.delete();
    rdy_low = 0;
    rw_max = 0;
    exp_entry = 32'd0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 20) begin @(negedge clk); n++; end
    if (!bus.rx_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout byte=%h rx_ready stayed %b, wanted 1", b, bus.rx_ready);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_ignored(input logic [7:0] b);
    @(negedge clk);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    vectors++;
    if (bus.rx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ignored_byte rx_ready got %b want 0", bus.rx_ready);
    end
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_stream(input string s);
    model_stream(s);
    for (int k = 0; k < s.len(); k++) begin
      if (k < n_acc) send_byte(s[k]);
      else send_ignored(s[k]);
    end
    repeat (4) @(negedge clk);
  endtask

  function automatic string hx(input logic [7:0] v, input bit lower);
    return lower ? $sformatf("%02x", v) : $sformatf("%02X", v);
  endfunction

  function automatic string mk_rec(input logic [7:0] t, input int alen,
                                   input logic [31:0] a, input int dl, input bit lower);
    string      s;
    logic [7:0] sum, b;
    s   = $sformatf("S%c", t);
    sum = 8'(dl + alen + 1);
    s   = {s, hx(sum, lower)};
    for (int k = alen - 1; k >= 0; k--) begin
      b = a[8*k +: 8]; sum += b; s = {s, hx(b, lower)};
    end
    for (int k = 0; k < dl; k++) begin
      b = 8'($urandom_range(0, 255)); sum += b; s = {s, hx(b, lower)};
    end
    return {s, hx(8'hFF - sum, lower), "\r\n"};
  endfunction

  // Tests
  task automatic test_reset();
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({bus.srec_parse, bus.rx_ready, bus.srec_rw, bus.done, bus.error} !== 5'b11000) begin
      miscompares++;
      $display("FAIL reset_flags got parse/rdy/rw/done/err=%b want 11000",
               {bus.srec_parse, bus.rx_ready, bus.srec_rw, bus.done, bus.error});
    end
    vectors++;
    if ({bus.srec_address, bus.srec_data_in, bus.entry_point} !== 96'd0) begin
      miscompares++;
      $display("FAIL reset_buses got a=%h d=%h e=%h want 0", bus.srec_address, bus.srec_data_in, bus.entry_point);
    end
    vectors++;
    if ({bus.error_code, bus.srec_access_size} !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_code got code=%0d sz=%b want 0/00", bus.error_code, bus.srec_access_size);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    apply_reset();
    run_stream("S1070000DEADBEEFC0\r\n");
    vectors++;
    if (got_q.size() !== 1 || exp_q.size() !== 1) begin
      miscompares++;
      $display("FAIL full_word count got %0d want 1 (model %0d)", got_q.size(), exp_q.size());
    end else begin
      vectors++;
      if (got_q[0] !== exp_q[0] || got_q[0] !== wr_t'{32'h0, 32'hDEADBEEF, 2'b00}) begin
        miscompares++;
        $display("FAIL full_word data got a=%h d=%h sz=%b want a=00000000 d=deadbeef sz=00",
                 got_q[0].a, got_q[0].d, got_q[0].sz);
      end
    end
    vectors++;
    if (rw_max !== 1) begin
      miscompares++;
      $display("FAIL full_word rw_width got %0d want 1", rw_max);
    end
    vectors++;
    if ({bus.error, bus.srec_parse, bus.rx_ready} !== 3'b011) begin
      miscompares++;
      $display("FAIL full_word status got err/parse/rdy=%b want 011",
               {bus.error, bus.srec_parse, bus.rx_ready});
    end
  endtask

  task automatic test_partial();
    apply_reset();
    run_stream("S1050010ABCD72");
    vectors++;
    if (got_q.size() !== 1) begin
      miscompares++;
      $display("FAIL partial count got %0d want 1", got_q.size());
    end else begin
      vectors++;
      if (got_q[0] !== exp_q[0] || got_q[0].d !== 32'hABCD0000 || got_q[0].a !== 32'h10) begin
        miscompares++;
        $display("FAIL partial data got a=%h d=%h want a=00000010 d=abcd0000", got_q[0].a, got_q[0].d);
      end
    end
    vectors++;
    if (rdy_low !== 1) begin
      miscompares++;
      $display("FAIL partial rdy_low_cycles got %0d want 1", rdy_low);
    end
  endtask

  task automatic test_term();
    apply_reset();
    run_stream("S1070000DEADBEEFC0\r\n");
    run_stream("S9030100FB");
    vectors++;
    if (bus.entry_point !== exp_entry || bus.entry_point !== 32'h100) begin
      miscompares++;
      $display("FAIL term entry got %h want 00000100 (model %h)", bus.entry_point, exp_entry);
    end
    vectors++;
    if ({bus.done, bus.srec_parse, bus.rx_ready, bus.error} !== 4'b1000) begin
      miscompares++;
      $display("FAIL term status got done/parse/rdy/err=%b want 1000",
               {bus.done, bus.srec_parse, bus.rx_ready, bus.error});
    end
  endtask

  task automatic test_error_codes();
    string errs  [6];
    int    codes [6];
    int    nwr   [6];
    errs  = '{"S1G5", "X", "S4", "S102", "S1050002ABCD80", "S1070000DEADBEEFC1S107"};
    codes = '{1, 6, 3, 5, 4, 2};
    nwr   = '{0, 0, 0, 0, 0, 1};
    for (int t = 0; t < 6; t++) begin
      apply_reset();
      run_stream(errs[t]);
      vectors++;
      if (int'(bus.error_code) !== codes[t] || exp_code !== codes[t]) begin
        miscompares++;
        $display("FAIL err_code[%0d] got %0d want %0d (model %0d)", t, bus.error_code, codes[t], exp_code);
      end
      vectors++;
      if ({bus.error, bus.srec_parse, bus.done, bus.rx_ready} !== 4'b1100) begin
        miscompares++;
        $display("FAIL err_status[%0d] got err/parse/done/rdy=%b want 1100", t,
                 {bus.error, bus.srec_parse, bus.done, bus.rx_ready});
      end
      vectors++;
      if (got_q.size() !== nwr[t] || exp_q.size() !== nwr[t]) begin
        miscompares++;
        $display("FAIL err_writes[%0d] got %0d want %0d", t, got_q.size(), nwr[t]);
      end else if (nwr[t] == 1) begin
        vectors++;
        if (got_q[0] !== exp_q[0]) begin
          miscompares++;
          $display("FAIL err_write_data[%0d] got a=%h d=%h want a=%h d=%h", t,
                   got_q[0].a, got_q[0].d, exp_q[0].a, exp_q[0].d);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    string s;
    apply_reset();
    s = "S1070000DE";
    for (int k = 0; k < s.len(); k++) send_byte(s[k]);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.srec_parse, bus.rx_ready, bus.srec_rw, bus.done, bus.error, bus.error_code} !== 8'b11000000 ||
        {bus.srec_address, bus.srec_data_in, bus.entry_point} !== 96'd0) begin
      miscompares++;
      $display("FAIL mid_reset outputs got flags=%b a=%h d=%h want reset values",
               {bus.srec_parse, bus.rx_ready, bus.srec_rw, bus.done, bus.error, bus.error_code},
               bus.srec_address, bus.srec_data_in);
    end
    vectors++;
    if (got_q.size() !== 0) begin
      miscompares++;
      $display("FAIL mid_reset stray_write got %0d want 0", got_q.size());
    end
    apply_reset();
    run_stream("S1070000DEADBEEFC0");
    vectors++;
    if (got_q.size() !== 1 || got_q[0] !== wr_t'{32'h0, 32'hDEADBEEF, 2'b00}) begin
      miscompares++;
      $display("FAIL mid_reset_reload got count=%0d want one write deadbeef@0", got_q.size());
    end
  endtask

  task automatic test_random();
    string       s;
    int          t, alen;
    logic [31:0] a;
    apply_reset();
    s = mk_rec("0", 2, 32'h0, 5, 1'b0);
    for (int n = 0; n < 20; n++) begin
      t    = $urandom_range(1, 3);
      alen = t + 1;
      a    = $urandom;
      a    = (alen == 2) ? (a & 32'h0000_FFFC) : (alen == 3) ? (a & 32'h00FF_FFFC) : (a & 32'hFFFF_FFFC);
      s    = {s, mk_rec(8'(48 + t), alen, a, $urandom_range(0, 13), 1'($urandom_range(0, 1)))};
    end
    s = {s, mk_rec("3", 4, 32'hFFFF_FFFC, 8, 1'b0)};
    s = {s, mk_rec("5", 2, 32'h0000_0015, 0, 1'b0)};
    t    = $urandom_range(7, 9);
    alen = 11 - t;
    a    = $urandom;
    if (alen == 2) a &= 32'h0000_FFFF;
    if (alen == 3) a &= 32'h00FF_FFFF;
    s = {s, mk_rec(8'(48 + t), alen, a, 0, 1'b1)};
    run_stream(s);
    vectors++;
    if (got_q.size() !== exp_q.size()) begin
      miscompares++;
      $display("FAIL random write_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      vectors++;
      if (got_q[k] !== exp_q[k]) begin
        miscompares++;
        $display("FAIL random write[%0d] got a=%h d=%h sz=%b want a=%h d=%h sz=%b", k,
                 got_q[k].a, got_q[k].d, got_q[k].sz, exp_q[k].a, exp_q[k].d, exp_q[k].sz);
      end
    end
    vectors++;
    if (bus.done !== 1'b1 || bus.error !== 1'b0 || bus.entry_point !== exp_entry || exp_done !== 1'b1) begin
      miscompares++;
      $display("FAIL random term got done=%b err=%b entry=%h want done=1 err=0 entry=%h",
               bus.done, bus.error, bus.entry_point, exp_entry);
    end
  endtask

  initial begin
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    test_reset();
    test_full_word();
    test_partial();
    test_term();
    test_error_codes();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/srec_loader.md
Name: srec_loader

Overview:
- Hardware Motorola S-record loader and the write side of the instruction-memory SREC port.
- Accepts an ASCII S-record byte stream, parses S0/S1/S2/S3/S5/S7/S8/S9 records and verifies each record checksum.
- Issues single-word writes into instruction memory through srec_address, srec_data_in, srec_rw and srec_access_size.
- Holds srec_parse high while loading so the processor's fetch muxes are steered away from memory; releases srec_parse on the termination record.

Parameters:
- ADDR_OFFSET, 32'h0000_0000, constant added to every parsed record address before it is driven on srec_address.
- WORD_ACCESS_SIZE, 2'b00, value driven on srec_access_size for every write (single 32-bit word).

Ports:
- clk  input  1  system clock; all state updates on posedge
- rst_n  input  1  asynchronous active-low reset
- rx_data  input  8  ASCII byte from the host stream
- rx_valid  input  1  rx_data is valid
- rx_ready  output  1  loader can accept a byte this cycle
- srec_parse  output  1  1 = loader owns instruction memory
- srec_address  output  32  word-aligned write address
- srec_data_in  output  32  write data, big-endian assembled
- srec_rw  output  1  write strobe, 1 = write
- srec_access_size  output  2  memory access size
- entry_point  output  32  start address from the S7/S8/S9 record
- done  output  1  sticky; a valid termination record has been parsed
- error  output  1  sticky; the parse failed
- error_code  output  3  cause of the first error

Behaviour:
- Reset (async, rst_n low): srec_parse=1, rx_ready=1, srec_rw=0, srec_address=0, srec_data_in=0, srec_access_size=WORD_ACCESS_SIZE, entry_point=0, done=0, error=0, error_code=0, FSM=IDLE. Reset mid-record discards all partial state; no write is issued.
- Handshake: a byte is consumed when rx_valid & rx_ready at posedge. rx_ready=0 in WRITE, DONE and ERROR.
- Hex: 0-9, A-F and a-f are accepted. Two nibbles form one byte, high nibble first.
- FSM states: IDLE, TYPE, COUNT, ADDR, DATA, CKSUM, WRITE, DONE, ERROR.
- IDLE: 'S' goes to TYPE. CR, LF and space are ignored. Any other character goes to ERROR with code 6.
- TYPE: the type digit sets the address length. 0, 1, 5 and 9 use 2 bytes; 2 and 8 use 3 bytes; 3 and 7 use 4 bytes. Digits 4 or 6, or any non-digit, go to ERROR with code 3.
- COUNT: one byte. If count < addr_len+1, go to ERROR with code 5. data_len = count - addr_len - 1.
- ADDR: addr_len bytes, MSB first, zero-extended to 32 bits.
  - For S1/S2/S3, if addr[1:0] != 0, go to ERROR with code 4 and issue no write.
  - For S7/S8/S9 the address is latched as the pending entry point.
- DATA: data_len bytes.
  - S1/S2/S3 bytes are packed into a word buffer at byte lanes [31:24], [23:16], [15:8], [7:0] in order. Each 4th byte goes to WRITE.
  - If the record ends with 1-3 bytes buffered, go to WRITE with the unused low lanes zero-padded, then continue to CKSUM.
  - S0/S5 data and any data bytes of S7/S8/S9 are checksummed but never written.
- WRITE: lasts exactly 1 cycle.
  - srec_rw=1; srec_address = word address + ADDR_OFFSET; srec_data_in = buffer.
  - The word address then advances by 4, modulo 2^32 (wrap permitted).
  - Afterwards return to DATA, or to CKSUM if data is exhausted.
  - srec_rw=0 in every other state.
- CKSUM: one byte.
  - The 8-bit sum (mod 256) of count, address, data and checksum bytes must equal 8'hFF; otherwise go to ERROR with code 2.
  - Words already written for a failing record are not rolled back; the error flag invalidates the whole load.
  - On a good S7/S8/S9 checksum: entry_point = pending address, done=1, srec_parse=0, go to DONE.
  - Otherwise return to IDLE.
- A non-hex character in COUNT, ADDR, DATA or CKSUM goes to ERROR with code 1.
- DONE and ERROR are absorbing until reset.
- In ERROR: srec_parse stays 1 (processor held), done=0, and error_code holds the first cause only.

Test Plan:
- Stream "S1070000DEADBEEFC0\r\n" -> exactly one 1-cycle srec_rw pulse with address 0x00000000, data 0xDEADBEEF, access_size 2'b00; loader returns to IDLE with error=0.
- Stream "S1050010ABCD72" -> one write with address 0x00000010, data 0xABCD0000 (zero-padded); rx_ready=0 during that cycle only.
- After the first record, stream "S9030100FB" -> entry_point=0x00000100, done=1, srec_parse falls to 0, rx_ready=0.
- Stream "S1070000DEADBEEFC1" -> the write to 0x0 still occurs, then error=1, error_code=2, srec_parse stays 1, later bytes are ignored.
- Stream "S1050002ABCD80" -> no srec_rw pulse, error_code=4. Separately, stream "S1G5" -> error_code=1, and stream "X" in IDLE -> error_code=6.
- Drop rst_n low after "S1070000DE" -> all outputs return to their reset values. Then stream "S1070000DEADBEEFC0" -> a single clean write of 0xDEADBEEF to 0x0.
